// File: rtl/path_delay_monitor_if.sv
// Control/status bundle for path_delay_monitor. min_delay/jitter_alarm exist only when
// PATH_DELAY_MONITOR_MINMAX_EN is defined.
interface path_delay_monitor_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] threshold;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] max_delay;
  logic             timeout;
  logic             alarm;
`ifdef PATH_DELAY_MONITOR_MINMAX_EN
  logic [CNT_W-1:0] min_delay;
  logic             jitter_alarm;

  modport master (
    output start, threshold,
    input  busy, done, max_delay, timeout, alarm, min_delay, jitter_alarm
  );
  modport slave (
    input  start, threshold,
    output busy, done, max_delay, timeout, alarm, min_delay, jitter_alarm
  );
`else
  modport master (
    output start, threshold,
    input  busy, done, max_delay, timeout, alarm
  );
  modport slave (
    input  start, threshold,
    output busy, done, max_delay, timeout, alarm
  );
`endif
endinterface

// File: rtl/path_delay_monitor.sv
// Launches transitions into a delay chain and measures worst-case arrival latency over several
// trials. Optional min/jitter tracking is enabled by PATH_DELAY_MONITOR_MINMAX_EN.
module path_delay_monitor #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_WAIT   = 1023,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned NUM_TRIALS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  path_delay_monitor_if.slave  bus,
  input  logic                 path_out,
  output logic                 path_in
);

  localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] MaxWait = CNT_W'(MAX_WAIT);
  localparam logic [SetW-1:0]  SetLast = SetW'(SETTLE_CYC - 1);
  localparam logic [7:0]       Trials  = 8'(NUM_TRIALS);

  typedef enum logic [2:0] {StIdle, StSettle, StLaunch, StWait, StNext, StDone} state_e;

  state_e           state;
  logic             sync1, ps, baseline;
  logic [SetW-1:0]  settle_cnt;
  logic [7:0]       trials;
  logic [CNT_W-1:0] cnt, thr;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + CNT_W'(1);

  // path_out is asynchronous to clk; only ps is ever looked at
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      ps    <= 1'b0;
    end else begin
      sync1 <= path_out;
      ps    <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= StIdle;
      path_in       <= 1'b0;
      baseline      <= 1'b0;
      settle_cnt    <= '0;
      trials        <= '0;
      cnt           <= '0;
      thr           <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.max_delay <= '0;
      bus.timeout   <= 1'b0;
      bus.alarm     <= 1'b0;
`ifdef PATH_DELAY_MONITOR_MINMAX_EN
      bus.min_delay    <= '0;
      bus.jitter_alarm <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.start) begin
            thr           <= bus.threshold;
            bus.max_delay <= '0;
            bus.timeout   <= 1'b0;
            bus.alarm     <= 1'b0;
`ifdef PATH_DELAY_MONITOR_MINMAX_EN
            bus.min_delay    <= '1;
            bus.jitter_alarm <= 1'b0;
`endif
            trials     <= Trials;
            settle_cnt <= '0;
            bus.busy   <= 1'b1;
            state      <= StSettle;
          end
        end
        StSettle: begin
          settle_cnt <= settle_cnt + SetW'(1);
          if (settle_cnt == SetLast) begin
            baseline <= ps;
            state    <= StLaunch;
          end
        end
        StLaunch: begin
          path_in <= ~path_in;
          cnt     <= '0;
          state   <= StWait;
        end
        StWait: begin
          if (cnt != '1) cnt <= cnt_inc;
          // Arrival takes priority over the wait limit when both land in one cycle
          if (ps != baseline) begin
            if (cnt_inc > bus.max_delay) bus.max_delay <= cnt_inc;
`ifdef PATH_DELAY_MONITOR_MINMAX_EN
            if (cnt_inc < bus.min_delay) bus.min_delay <= cnt_inc;
`endif
            state <= StNext;
          end else if (cnt_inc == MaxWait) begin
            bus.timeout   <= 1'b1;
            bus.max_delay <= MaxWait;
`ifdef PATH_DELAY_MONITOR_MINMAX_EN
            if (MaxWait < bus.min_delay) bus.min_delay <= MaxWait;
`endif
            state <= StNext;
          end
        end
        StNext: begin
          trials <= trials - 8'd1;
          if (trials == 8'd1) begin
            state <= StDone;
          end else begin
            settle_cnt <= '0;
            state      <= StSettle;
          end
        end
        StDone: begin
          bus.alarm <= bus.timeout | (bus.max_delay > thr);
`ifdef PATH_DELAY_MONITOR_MINMAX_EN
          bus.jitter_alarm <= (bus.max_delay - bus.min_delay) > CNT_W'(2);
`endif
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
